// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ctrl_sequencer
// Brief   : Multi-cycle instruction sequencer (DECODE/EXEC/MEM/WB) with stall
//           hold and an illegal-opcode ERR path.
// Revision: 1.0
// ============================================================================
module ctrl_sequencer #(
  parameter int OPCODE_W    = 7,
  parameter int SIG_W       = 23,
  parameter int EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  output logic                instr_ready,
  output logic [SIG_W-1:0]    signals,
  output logic                busy,
  output logic                mem_phase,
  output logic                done,
  output logic                illegal
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_decode = 3'd1;
  localparam logic [2:0] c_st_exec   = 3'd2;
  localparam logic [2:0] c_st_mem    = 3'd3;
  localparam logic [2:0] c_st_wb     = 3'd4;
  localparam logic [2:0] c_st_err    = 3'd5;

  localparam logic [3:0] c_exec_last = 4'(EXEC_CYCLES - 1);

  localparam logic [6:0] c_op_alu   = 7'b0010001;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_imm   = 7'b0011001;
  localparam logic [6:0] c_op_store = 7'b0011000;

  localparam logic [22:0] c_word_alu   = 23'b01110100000101001100011;
  localparam logic [22:0] c_word_load  = 23'b01110101000100001100011;
  localparam logic [22:0] c_word_imm   = 23'b01100100000101011100011;
  localparam logic [22:0] c_word_store = 23'b01111100000101011100011;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [3:0]          r_cnt;
  logic [OPCODE_W-1:0] r_opcode;
  logic [SIG_W-1:0]    r_word;
  logic [SIG_W-1:0]    w_word;
  logic                w_upper_zero;
  logic                w_legal;
  logic                w_is_load;
  logic                w_accept;
  logic                w_exec_last;

  // Opcodes wider than the 7-bit table are only legal with the extra bits clear.
  generate
    if (OPCODE_W > 7) begin : g_upper_chk
      assign w_upper_zero = ~|r_opcode[OPCODE_W-1:7];
    end else begin : g_no_upper
      assign w_upper_zero = 1'b1;
    end
  endgenerate

  always_comb begin
    w_word  = '0;
    w_legal = 1'b0;
    if (w_upper_zero) begin
      w_legal = 1'b1;
      case (r_opcode[6:0])
        c_op_alu:   w_word[22:0] = c_word_alu;
        c_op_load:  w_word[22:0] = c_word_load;
        c_op_imm:   w_word[22:0] = c_word_imm;
        c_op_store: w_word[22:0] = c_word_store;
        default:    w_legal      = 1'b0;
      endcase
    end
  end

  assign w_is_load   = w_upper_zero && (r_opcode[6:0] == c_op_load);
  assign w_accept    = instr_valid && instr_ready;
  assign w_exec_last = (r_cnt == c_exec_last);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= c_st_idle;
      r_cnt    <= 4'd0;
      r_opcode <= '0;
      r_word   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_opcode <= opcode;
      end
      if ((r_state == c_st_decode) && !stall) begin
        r_cnt  <= 4'd0;
        r_word <= w_word;
      end else if ((r_state == c_st_exec) && !stall && !w_exec_last) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_accept) w_state_nxt = c_st_decode;
      end
      c_st_decode: begin
        if (!stall) w_state_nxt = w_legal ? c_st_exec : c_st_err;
      end
      c_st_exec: begin
        if (!stall && w_exec_last) w_state_nxt = w_is_load ? c_st_mem : c_st_wb;
      end
      c_st_mem: begin
        if (!stall) w_state_nxt = c_st_wb;
      end
      c_st_wb: begin
        if (!stall) w_state_nxt = c_st_idle;
      end
      c_st_err: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Pulses are suppressed in a reset cycle since that edge aborts the instruction.
  always_comb begin
    instr_ready = 1'b0;
    signals     = '0;
    busy        = 1'b1;
    mem_phase   = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      c_st_idle: begin
        busy        = 1'b0;
        instr_ready = !stall && !reset;
      end
      c_st_exec: begin
        signals = r_word;
      end
      c_st_mem: begin
        signals   = r_word;
        mem_phase = 1'b1;
      end
      c_st_wb: begin
        signals = r_word;
        done    = !stall && !reset;
      end
      c_st_err: begin
        illegal = !reset;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// Testbench for ctrl_sequencer: two instances (7-bit/EXEC=1 and 9-bit/EXEC=3)
// driven with directed then random stimulus and compared to a schedule model.
module tb_ctrl_sequencer;

  localparam int c_exec0 = 1;
  localparam int c_exec1 = 3;

  typedef enum int {P_DEC, P_EXEC, P_MEM, P_WB, P_ERR} phase_t;
  typedef phase_t sched_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [8:0]  opcode;
  logic        stall;

  logic        rdy0, busy0, mem0, done0, ill0;
  logic [22:0] sig0;
  logic        rdy1, busy1, mem1, done1, ill1;
  logic [24:0] sig1;

  always #5 clk = ~clk;

  ctrl_sequencer u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .opcode     (opcode[6:0]),
    .stall      (stall),
    .instr_ready(rdy0),
    .signals    (sig0),
    .busy       (busy0),
    .mem_phase  (mem0),
    .done       (done0),
    .illegal    (ill0)
  );

  ctrl_sequencer #(
    .OPCODE_W   (9),
    .SIG_W      (25),
    .EXEC_CYCLES(c_exec1)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .instr_valid(instr_valid),
    .opcode     (opcode),
    .stall      (stall),
    .instr_ready(rdy1),
    .signals    (sig1),
    .busy       (busy1),
    .mem_phase  (mem1),
    .done       (done1),
    .illegal    (ill1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode table, indexed by the full 9-bit opcode.
  function automatic void ref_decode(input logic [8:0] op, output logic legal,
                                     output logic load, output logic [24:0] word);
    legal = 1'b1;
    load  = (op == 9'h003);
    word  = '0;
    case (op)
      9'h011:  word = 25'(23'b01110100000101001100011);
      9'h003:  word = 25'(23'b01110101000100001100011);
      9'h019:  word = 25'(23'b01100100000101011100011);
      9'h018:  word = 25'(23'b01111100000101011100011);
      default: legal = 1'b0;
    endcase
  endfunction

  // Each entry is one phase that consumes one non-stalled cycle (ERR ignores stall).
  function automatic sched_t schedule(input logic legal, input logic load, input int ncyc);
    sched_t s;
    s.push_back(P_DEC);
    if (!legal) begin
      s.push_back(P_ERR);
    end else begin
      for (int i = 0; i < ncyc; i++) s.push_back(P_EXEC);
      if (load) s.push_back(P_MEM);
      s.push_back(P_WB);
    end
    return s;
  endfunction

  sched_t      q0;
  sched_t      q1;
  logic [24:0] mw0 = '0;
  logic [24:0] mw1 = '0;

  task automatic expect_out(input bit empty, input phase_t t, input logic [24:0] w,
                            input logic st, input logic rs,
                            output logic e_rdy, output logic e_busy, output logic e_mem,
                            output logic e_done, output logic e_ill, output logic [24:0] e_sig);
    e_rdy  = empty && !st && !rs;
    e_busy = !empty;
    e_mem  = !empty && (t == P_MEM);
    e_done = !empty && (t == P_WB) && !st && !rs;
    e_ill  = !empty && (t == P_ERR) && !rs;
    e_sig  = (!empty && (t == P_EXEC || t == P_MEM || t == P_WB)) ? w : 25'd0;
  endtask

  task automatic cycle(input logic v, input logic [8:0] op, input logic st, input logic rs);
    logic        e_rdy, e_busy, e_mem, e_done, e_ill;
    logic [24:0] e_sig;
    logic        legal, load;
    logic [24:0] word;
    instr_valid = v;
    opcode      = op;
    stall       = st;
    reset       = rs;
    @(negedge clk);
    expect_out(q0.size() == 0, (q0.size() != 0) ? q0[0] : P_DEC, mw0, st, rs,
               e_rdy, e_busy, e_mem, e_done, e_ill, e_sig);
    chk("d0.ready",   32'(rdy0),  32'(e_rdy));
    chk("d0.busy",    32'(busy0), 32'(e_busy));
    chk("d0.mem",     32'(mem0),  32'(e_mem));
    chk("d0.done",    32'(done0), 32'(e_done));
    chk("d0.illegal", 32'(ill0),  32'(e_ill));
    chk("d0.signals", 32'(sig0),  32'(e_sig));
    expect_out(q1.size() == 0, (q1.size() != 0) ? q1[0] : P_DEC, mw1, st, rs,
               e_rdy, e_busy, e_mem, e_done, e_ill, e_sig);
    chk("d1.ready",   32'(rdy1),  32'(e_rdy));
    chk("d1.busy",    32'(busy1), 32'(e_busy));
    chk("d1.mem",     32'(mem1),  32'(e_mem));
    chk("d1.done",    32'(done1), 32'(e_done));
    chk("d1.illegal", 32'(ill1),  32'(e_ill));
    chk("d1.signals", 32'(sig1),  32'(e_sig));
    // Advance the model to what the coming rising edge should produce.
    if (rs) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() != 0) begin
        if (!st || q0[0] == P_ERR) void'(q0.pop_front());
      end else if (v && !st) begin
        ref_decode({2'b00, op[6:0]}, legal, load, word);
        q0  = schedule(legal, load, c_exec0);
        mw0 = word;
      end
      if (q1.size() != 0) begin
        if (!st || q1[0] == P_ERR) void'(q1.pop_front());
      end else if (v && !st) begin
        ref_decode(op, legal, load, word);
        q1  = schedule(legal, load, c_exec1);
        mw1 = word;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [6:0] legal_ops [4] = '{7'h11, 7'h03, 7'h19, 7'h18};

  initial begin
    logic       v, st, rs;
    logic [8:0] op;
    int         sel;
    reset       = 1'b1;
    instr_valid = 1'b0;
    opcode      = '0;
    stall       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    repeat (2) cycle(1'b1, 9'h011, 1'b0, 1'b1);

    // Basic ALU op, then load, then an undecodable opcode.
    cycle(1'b1, 9'h011, 1'b0, 1'b0);
    repeat (6) cycle(1'b0, 9'h1ff, 1'b0, 1'b0);
    cycle(1'b1, 9'h003, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 9'h000, 1'b0, 1'b0);
    cycle(1'b1, 9'h07f, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 9'h000, 1'b0, 1'b0);

    // Four stalled cycles starting in the first EXEC cycle.
    cycle(1'b1, 9'h018, 1'b0, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 9'h000, 1'b1, 1'b0);
    repeat (6) cycle(1'b0, 9'h000, 1'b0, 1'b0);

    // Reset mid-instruction, then an immediate new acceptance.
    cycle(1'b1, 9'h019, 1'b0, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b0);
    cycle(1'b0, 9'h000, 1'b0, 1'b1);
    cycle(1'b1, 9'h011, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 9'h000, 1'b0, 1'b0);

    // Nonzero upper opcode bits: legal for the 7-bit instance only.
    cycle(1'b1, 9'h111, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 9'h000, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 9) < 6);
      st  = ($urandom_range(0, 3) == 0);
      rs  = ($urandom_range(0, 59) == 0);
      sel = int'($urandom_range(0, 7));
      if (sel < 5)       op = {2'b00, legal_ops[$urandom_range(0, 3)]};
      else if (sel == 5) op = 9'($urandom);
      else if (sel == 6) op = {2'($urandom_range(1, 3)), legal_ops[$urandom_range(0, 3)]};
      else               op = 9'h07f;
      cycle(v, op, st, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 7: opcode width; SHALL be >= 7.
REQ-002 Parameter SIG_W, default 23: control-word width; SHALL be >= 23, with bits above 22 driven 0.
REQ-003 Parameter EXEC_CYCLES, default 1: EXEC-phase length in cycles; SHALL be 1..15.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 instr_valid  input  1  opcode offered this cycle.
REQ-007 opcode  input  OPCODE_W  instruction opcode, sampled on acceptance only.
REQ-008 stall  input  1  freeze request from pipeline.
REQ-009 instr_ready  output  1  block can accept an opcode.
REQ-010 signals  output  SIG_W  decoded control word.
REQ-011 busy  output  1  instruction in flight.
REQ-012 mem_phase  output  1  MEM state active.
REQ-013 done  output  1  instruction retire pulse.
REQ-014 illegal  output  1  undecodable-opcode pulse.

Function
REQ-015 States SHALL be IDLE, DECODE, EXEC, MEM, WB, ERR, in a registered state register.
REQ-016 Acceptance SHALL occur when instr_valid & instr_ready; opcode is latched, state moves IDLE->DECODE.
REQ-017 instr_ready SHALL be 1 only in IDLE with stall=0 and reset=0.
REQ-018 Decode table (upper OPCODE_W-7 bits must be 0): 0010001->01110100000101001100011; 0000011->01110101000100001100011 (load); 0011001->01100100000101011100011; 0011000->01111100000101011100011 (words listed MSB..bit 0).
REQ-019 DECODE SHALL last one cycle: legal opcode -> EXEC with word latched; otherwise -> ERR.
REQ-020 EXEC SHALL last exactly EXEC_CYCLES non-stalled cycles, counted by a 4-bit counter cleared on EXEC entry.
REQ-021 Leaving EXEC: load opcode -> MEM (one cycle) -> WB; others -> WB directly.
REQ-022 WB SHALL last one non-stalled cycle, then -> IDLE.
REQ-023 ERR SHALL last one cycle, then -> IDLE; stall SHALL NOT extend ERR.
REQ-024 signals SHALL equal the latched word in EXEC, MEM, WB and all-zero in IDLE, DECODE, ERR.
REQ-025 busy SHALL be 1 in every state except IDLE; mem_phase SHALL be 1 only in MEM.
REQ-026 done SHALL be 1 only in a WB cycle with stall=0 (exactly once per legal instruction).
REQ-027 illegal SHALL be 1 only in the ERR cycle; signals stays zero and done stays 0.
REQ-028 stall=1 in DECODE, EXEC, MEM, WB SHALL hold state, counter, latched word and all outputs (done forced 0).
REQ-029 opcode/instr_valid changes after acceptance SHALL have no effect until next IDLE.
REQ-030 Latency, stall-free, accept at cycle T: non-load done at T+2+EXEC_CYCLES; load at T+3+EXEC_CYCLES; next acceptance possible one cycle after done.

Reset
REQ-031 reset=1 at an edge SHALL force state IDLE, counter 0, latched opcode and word 0, regardless of state or stall.
REQ-032 During and after reset until first acceptance: signals=0, busy=0, mem_phase=0, done=0, illegal=0; instr_ready=0 while reset=1, 1 on first cycle after release (if stall=0).
REQ-033 Reset mid-instruction SHALL abort it with no done or illegal pulse.

Verification
REQ-034 Defaults, accept 0010001 at T, no stall -> signals=01110100000101001100011 at T+2..T+3, done=1 at T+3, instr_ready=1 at T+4.
REQ-035 Accept 0000011, EXEC_CYCLES=3 -> EXEC T+2..T+4, mem_phase=1 at T+5, done=1 at T+6.
REQ-036 Accept 1111111 -> illegal=1 at T+2 only, signals=0 throughout, done never asserted, instr_ready=1 at T+3.
REQ-037 Accept 0011000, stall=1 for 4 cycles from T+2 -> signals held 01111100000101011100011, done delayed to T+7, single pulse.
REQ-038 Accept 0011001, reset=1 at T+2 -> state IDLE, signals=0 at T+3, no done; new opcode accepted at T+3.
